// File: rtl/mm_latency_model.sv
`default_nettype none
// ============================================================================
// Module      : mm_latency_model
// Description : Main-memory responder for a non-blocking cache. Accepts miss
//               requests into a small pool of slots, holds each one for an
//               address-dependent latency, and returns fill data tagged with
//               the op id. Fills may therefore come back out of order. A
//               separate write port preloads the backing array.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_latency_model #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int NUM_OPS      = 32,
    parameter int MEM_DEPTH    = 256,
    parameter int NUM_SLOTS    = 4,
    parameter int BASE_LATENCY = 4,
    parameter int LAT_STEP     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_WIDTH-1:0]      mm_req,
    input  logic [$clog2(NUM_OPS)-1:0] mm_req_op,
    input  logic                       mm_req_valid,
    output logic [DATA_WIDTH-1:0]      mm_ret_data,
    output logic [$clog2(NUM_OPS)-1:0] mm_ret_op,
    output logic                       mm_ret_valid,
    input  logic                       wr_en,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       busy,
    output logic                       overflow
);

    localparam int c_op_w    = $clog2(NUM_OPS);
    localparam int c_idx_w   = $clog2(MEM_DEPTH);
    localparam int c_max_lat = BASE_LATENCY + 3 * LAT_STEP;
    // Counter holds latency minus one, so it never needs to represent c_max_lat.
    localparam int c_cnt_w   = (c_max_lat > 1) ? $clog2(c_max_lat) : 1;

    typedef logic [c_cnt_w-1:0] cnt_t;

    typedef enum logic [1:0] {
        SLOT_FREE  = 2'd0,
        SLOT_WAIT  = 2'd1,
        SLOT_READY = 2'd2
    } slot_state_t;

    slot_state_t              state_q [NUM_SLOTS];
    slot_state_t              state_d [NUM_SLOTS];
    cnt_t                     cnt_q   [NUM_SLOTS];
    cnt_t                     cnt_d   [NUM_SLOTS];
    logic [c_idx_w-1:0]       idx_q   [NUM_SLOTS];
    logic [c_idx_w-1:0]       idx_d   [NUM_SLOTS];
    logic [c_op_w-1:0]        op_q    [NUM_SLOTS];
    logic [c_op_w-1:0]        op_d    [NUM_SLOTS];

    logic [DATA_WIDTH-1:0]    mem_q   [MEM_DEPTH];

    logic                     mm_ret_valid_q, mm_ret_valid_d;
    logic [DATA_WIDTH-1:0]    mm_ret_data_q,  mm_ret_data_d;
    logic [c_op_w-1:0]        mm_ret_op_q,    mm_ret_op_d;
    logic                     overflow_q,     overflow_d;

    logic [c_idx_w-1:0]       w_req_idx;
    logic [c_idx_w-1:0]       w_wr_idx;
    cnt_t                     w_lat_m1;
    logic [NUM_SLOTS-1:0]     w_acc;
    logic [NUM_SLOTS-1:0]     w_sel;
    logic                     w_any_free;
    logic                     w_any_ready;
    logic [c_idx_w-1:0]       w_ret_idx;
    logic [c_op_w-1:0]        w_ret_op;
    logic                     w_busy;
    logic                     w_unused_addr;

    // Only the index bits address the array; upper address bits alias.
    assign w_req_idx     = mm_req[c_idx_w-1:0];
    assign w_wr_idx      = wr_addr[c_idx_w-1:0];
    assign w_unused_addr = ^{mm_req[ADDR_WIDTH-1:c_idx_w], wr_addr[ADDR_WIDTH-1:c_idx_w]};

    // Countdown preload: a request accepted at edge T becomes selectable at edge T+L.
    assign w_lat_m1 = cnt_t'(BASE_LATENCY - 1) + cnt_t'(mm_req[1:0]) * cnt_t'(LAT_STEP);

    // Lowest-index free slot takes the request; lowest-index ready slot wins the return.
    always_comb begin
        w_acc       = '0;
        w_sel       = '0;
        w_any_free  = 1'b0;
        w_any_ready = 1'b0;
        w_ret_idx   = '0;
        w_ret_op    = '0;
        w_busy      = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (state_q[i] != SLOT_FREE) begin
                w_busy = 1'b1;
            end
            if (!w_any_free && state_q[i] == SLOT_FREE) begin
                w_any_free = 1'b1;
                w_acc[i]   = mm_req_valid;
            end
            if (!w_any_ready && state_q[i] == SLOT_READY) begin
                w_any_ready = 1'b1;
                w_sel[i]    = 1'b1;
                w_ret_idx   = idx_q[i];
                w_ret_op    = op_q[i];
            end
        end
    end

    // Per-slot lifecycle: capture on accept, count down, wait to be selected.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            idx_d[i]   = idx_q[i];
            op_d[i]    = op_q[i];
            case (state_q[i])
                SLOT_FREE: begin
                    if (w_acc[i]) begin
                        idx_d[i]   = w_req_idx;
                        op_d[i]    = mm_req_op;
                        cnt_d[i]   = w_lat_m1;
                        state_d[i] = (w_lat_m1 == '0) ? SLOT_READY : SLOT_WAIT;
                    end
                end
                SLOT_WAIT: begin
                    cnt_d[i] = cnt_q[i] - cnt_t'(1);
                    if (cnt_q[i] == cnt_t'(1)) begin
                        state_d[i] = SLOT_READY;
                    end
                end
                SLOT_READY: begin
                    if (w_sel[i]) begin
                        state_d[i] = SLOT_FREE;
                    end
                end
                default: begin
                    state_d[i] = SLOT_FREE;
                end
            endcase
        end
    end

    // Return path reads the array before this edge's write lands; outputs hold when idle.
    always_comb begin
        mm_ret_valid_d = w_any_ready;
        mm_ret_data_d  = mm_ret_data_q;
        mm_ret_op_d    = mm_ret_op_q;
        if (w_any_ready) begin
            mm_ret_data_d = mem_q[w_ret_idx];
            mm_ret_op_d   = w_ret_op;
        end
        overflow_d = overflow_q | (mm_req_valid & ~w_any_free);
    end

    // Slot and output registers; reset discards everything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= SLOT_FREE;
                cnt_q[i]   <= '0;
                idx_q[i]   <= '0;
                op_q[i]    <= '0;
            end
            mm_ret_valid_q <= 1'b0;
            mm_ret_data_q  <= '0;
            mm_ret_op_q    <= '0;
            overflow_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                idx_q[i]   <= idx_d[i];
                op_q[i]    <= op_d[i];
            end
            mm_ret_valid_q <= mm_ret_valid_d;
            mm_ret_data_q  <= mm_ret_data_d;
            mm_ret_op_q    <= mm_ret_op_d;
            overflow_q     <= overflow_d;
        end
    end

    // Backing array is deliberately outside reset so preloaded contents survive it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[w_wr_idx] <= wr_data;
        end
    end

    assign mm_ret_valid = mm_ret_valid_q;
    assign mm_ret_data  = mm_ret_data_q;
    assign mm_ret_op    = mm_ret_op_q;
    assign overflow     = overflow_q;
    assign busy         = w_busy;

endmodule
`default_nettype wire
